// File: rtl/bp_be_rpt_nway.sv
// N-way reference prediction table: learns per-PC load strides and issues
// confident prefetch addresses through a valid/ready port.
module bp_be_rpt_nway #(
    parameter int vaddr_width_p   = 39,
    parameter int sets_p          = 32,
    parameter int ways_p          = 4,
    parameter int stride_width_p  = 12,
    parameter int ctr_width_p     = 2,
    parameter int conf_thresh_p   = 2,
    parameter int prefetch_dist_p = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     flush_i,
    output logic                     init_done_o,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [vaddr_width_p-1:0] pc_i,
    input  logic [vaddr_width_p-1:0] eff_addr_i,
    output logic                     pf_v_o,
    input  logic                     pf_ready_i,
    output logic [vaddr_width_p-1:0] pf_addr_o,
    output logic [vaddr_width_p-1:0] pf_pc_o
);

    localparam int idx_w = $clog2(sets_p);
    localparam int tag_w = vaddr_width_p - idx_w;
    localparam int ptr_w = $clog2(ways_p);
    localparam logic [idx_w-1:0]         last_set_c = idx_w'(sets_p - 1);
    localparam logic [ctr_width_p-1:0]   thresh_c   = ctr_width_p'(conf_thresh_p);
    localparam logic [vaddr_width_p-1:0] dist_c     = vaddr_width_p'(prefetch_dist_p);

    typedef struct packed {
        logic                      valid;
        logic [tag_w-1:0]          tag;
        logic [vaddr_width_p-1:0]  last_addr;
        logic [stride_width_p-1:0] stride;
        logic [ctr_width_p-1:0]    ctr;
    } entry_t;

    typedef struct packed {
        entry_t [ways_p-1:0] way;
        logic   [ptr_w-1:0]  ptr;
    } row_t;

    typedef enum logic [1:0] {e_reset, e_clear, e_run} state_e;

    state_e                     state_q, state_n;
    logic [idx_w-1:0]           clr_cnt_q;
    logic                       run, accept;
    logic                       s1_v_q, s1_fire;
    logic [vaddr_width_p-1:0]   s1_pc_q, s1_addr_q;
    logic [idx_w-1:0]           s0_idx, s1_idx;
    logic [tag_w-1:0]           s1_tag;
    row_t                       rd_row_q, wr_row, mem_wdata;
    row_t                       mem [sets_p];
    logic                       mem_we;
    logic [idx_w-1:0]           mem_waddr;
    logic                       hit, has_free;
    logic [ptr_w-1:0]           hit_way, free_way, inst_way;
    entry_t                     old_e, upd_e;
    logic [stride_width_p-1:0]  new_stride;
    logic [vaddr_width_p-1:0]   stride_ext, pf_addr_n;
    logic                       pf_new;
    logic                       pf_v_q;
    logic [vaddr_width_p-1:0]   pf_addr_q, pf_pc_q;

    always_comb begin
        state_n = state_q;
        case (state_q)
            e_reset: state_n = e_clear;
            e_clear: if (clr_cnt_q == last_set_c) state_n = e_run;
            e_run:   if (flush_i) state_n = e_clear;
            default: state_n = e_reset;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_reset;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == e_clear)
                clr_cnt_q <= clr_cnt_q + idx_w'(1);
            else
                clr_cnt_q <= '0;
        end
    end

    assign run         = (state_q == e_run);
    assign init_done_o = run;
    assign ready_o     = run & ~flush_i & (~pf_v_q | pf_ready_i);
    assign accept      = v_i & ready_o;
    assign s0_idx      = pc_i[idx_w-1:0];
    assign s1_idx      = s1_pc_q[idx_w-1:0];
    assign s1_tag      = s1_pc_q[vaddr_width_p-1:idx_w];
    // A flush discards whatever observation is sitting in stage 1
    assign s1_fire     = s1_v_q & ~flush_i;

    // Lowest matching / lowest free way wins, hence the descending scan
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = ways_p - 1; w >= 0; w--) begin
            if (rd_row_q.way[w].valid && (rd_row_q.way[w].tag == s1_tag)) begin
                hit     = 1'b1;
                hit_way = ptr_w'(w);
            end
            if (!rd_row_q.way[w].valid) begin
                has_free = 1'b1;
                free_way = ptr_w'(w);
            end
        end

        old_e      = rd_row_q.way[hit_way];
        new_stride = stride_width_p'(s1_addr_q - old_e.last_addr);
        upd_e      = old_e;
        if (new_stride == old_e.stride) begin
            if (old_e.ctr != '1)
                upd_e.ctr = old_e.ctr + ctr_width_p'(1);
        end else if (old_e.ctr != '0) begin
            upd_e.ctr = old_e.ctr - ctr_width_p'(1);
        end else begin
            upd_e.stride = new_stride;
        end
        upd_e.last_addr = s1_addr_q;

        inst_way = has_free ? free_way : rd_row_q.ptr;
        wr_row   = rd_row_q;
        if (hit) begin
            wr_row.way[hit_way] = upd_e;
        end else begin
            wr_row.way[inst_way] = '{valid: 1'b1, tag: s1_tag, last_addr: s1_addr_q,
                                     stride: '0, ctr: '0};
            if (!has_free)
                wr_row.ptr = rd_row_q.ptr + ptr_w'(1);
        end

        stride_ext = {{(vaddr_width_p - stride_width_p){upd_e.stride[stride_width_p-1]}},
                      upd_e.stride};
        pf_addr_n  = s1_addr_q + stride_ext * dist_c;
        pf_new     = s1_fire & hit & (upd_e.ctr >= thresh_c) & (upd_e.stride != '0);
    end

    always_comb begin
        mem_we    = (state_q == e_clear) | s1_fire;
        mem_waddr = (state_q == e_clear) ? clr_cnt_q : s1_idx;
        mem_wdata = (state_q == e_clear) ? '0 : wr_row;
    end

    // Table storage is not reset; the clear sweep initialises every row
    always_ff @(posedge clk_i) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v_q    <= 1'b0;
            s1_pc_q   <= '0;
            s1_addr_q <= '0;
            rd_row_q  <= '0;
        end else begin
            s1_v_q <= accept;
            if (accept) begin
                s1_pc_q   <= pc_i;
                s1_addr_q <= eff_addr_i;
                rd_row_q  <= (s1_fire && (s0_idx == s1_idx)) ? wr_row : mem[s0_idx];
            end
        end
    end

    // A new prefetch arriving while the port is stalled is dropped; the
    // table update itself is always committed
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pf_v_q    <= 1'b0;
            pf_addr_q <= '0;
            pf_pc_q   <= '0;
        end else if (pf_new && (!pf_v_q || pf_ready_i)) begin
            pf_v_q    <= 1'b1;
            pf_addr_q <= pf_addr_n;
            pf_pc_q   <= s1_pc_q;
        end else if (pf_ready_i) begin
            pf_v_q <= 1'b0;
        end
    end

    assign pf_v_o    = pf_v_q;
    assign pf_addr_o = pf_addr_q;
    assign pf_pc_o   = pf_pc_q;

endmodule

// File: tb/tb_bp_be_rpt_nway.sv
// Bench for bp_be_rpt_nway: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level stride table model.
module tb_bp_be_rpt_nway;

    localparam int va_w     = 39;
    localparam int sets_c   = 32;
    localparam int idx_w    = 5;
    localparam int ways_c   = 4;
    localparam int stride_w = 12;
    localparam int ctr_max  = 3;
    localparam int thresh_c = 2;
    localparam int dist_c   = 1;

    logic            clk;
    logic            reset_n_i;
    logic            flush_i;
    logic            init_done_o;
    logic            v_i;
    logic            ready_o;
    logic [va_w-1:0] pc_i;
    logic [va_w-1:0] eff_addr_i;
    logic            pf_v_o;
    logic            pf_ready_i;
    logic [va_w-1:0] pf_addr_o;
    logic [va_w-1:0] pf_pc_o;

    bp_be_rpt_nway dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n_i),
        .flush_i     (flush_i),
        .init_done_o (init_done_o),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .pc_i        (pc_i),
        .eff_addr_i  (eff_addr_i),
        .pf_v_o      (pf_v_o),
        .pf_ready_i  (pf_ready_i),
        .pf_addr_o   (pf_addr_o),
        .pf_pc_o     (pf_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              valid;
        logic [va_w-1:0] pc;
        logic [va_w-1:0] last;
        int              stride;
        int              ctr;
    } ment_t;

    ment_t           tbl [sets_c][ways_c];
    int              vptr [sets_c];
    int              m_busy;
    bit              m_p_v;
    logic [va_w-1:0] m_p_pc, m_p_addr;
    bit              m_pf_v;
    logic [va_w-1:0] m_pf_addr, m_pf_pc;

    int n_cmp = 0;
    int n_err = 0;

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", name, obs, exp);
        end
    endtask

    task automatic modelClear();
        for (int s = 0; s < sets_c; s++) begin
            vptr[s] = 0;
            for (int w = 0; w < ways_c; w++) tbl[s][w] = '{1'b0, '0, '0, 0, 0};
        end
    endtask

    // One observation applied to the table in program order
    task automatic modelUpdate(input logic [va_w-1:0] pc, input logic [va_w-1:0] addr,
                               output bit pf, output logic [va_w-1:0] pfa);
        int              idx, way, ns;
        logic [va_w-1:0] diff;
        longint          off;
        pf  = 1'b0;
        pfa = '0;
        idx = int'(pc[idx_w-1:0]);
        way = -1;
        for (int w = 0; w < ways_c; w++)
            if (way < 0 && tbl[idx][w].valid && tbl[idx][w].pc == pc) way = w;
        if (way >= 0) begin
            diff = addr - tbl[idx][way].last;
            ns   = int'(diff[stride_w-1:0]);
            if (ns >= 2 ** (stride_w - 1)) ns -= 2 ** stride_w;
            if (ns == tbl[idx][way].stride) begin
                if (tbl[idx][way].ctr < ctr_max) tbl[idx][way].ctr++;
            end else if (tbl[idx][way].ctr > 0) begin
                tbl[idx][way].ctr--;
            end else begin
                tbl[idx][way].stride = ns;
            end
            tbl[idx][way].last = addr;
            if (tbl[idx][way].ctr >= thresh_c && tbl[idx][way].stride != 0) begin
                pf  = 1'b1;
                off = longint'(tbl[idx][way].stride) * dist_c;
                pfa = addr + off[va_w-1:0];
            end
        end else begin
            for (int w = 0; w < ways_c; w++)
                if (way < 0 && !tbl[idx][w].valid) way = w;
            if (way < 0) begin
                way       = vptr[idx];
                vptr[idx] = (vptr[idx] + 1) % ways_c;
            end
            tbl[idx][way] = '{1'b1, pc, addr, 0, 0};
        end
    endtask

    // Drives one cycle of inputs, advances the model across the clock edge
    // and compares every output on the following falling edge
    task automatic applyStimulus(input bit v, input logic [va_w-1:0] pc, input logic [va_w-1:0] addr,
                                 input bit rdy, input bit fl, output bit acc);
        bit              run, exp_ready, pfn;
        logic [va_w-1:0] pfa;
        v_i        = v;
        pc_i       = pc;
        eff_addr_i = addr;
        pf_ready_i = rdy;
        flush_i    = fl;
        #1;
        run       = (m_busy == 0);
        exp_ready = run && !fl && (!m_pf_v || rdy);
        checkOutput("ready_o", 64'(ready_o), 64'(exp_ready));
        acc = v && exp_ready;
        pfn = 1'b0;
        pfa = '0;
        if (m_p_v && !(run && fl)) modelUpdate(m_p_pc, m_p_addr, pfn, pfa);
        if (pfn && (!m_pf_v || rdy)) begin
            m_pf_v    = 1'b1;
            m_pf_addr = pfa;
            m_pf_pc   = m_p_pc;
        end else if (rdy) begin
            m_pf_v = 1'b0;
        end
        m_p_v    = acc;
        m_p_pc   = pc;
        m_p_addr = addr;
        if (run && fl) begin
            modelClear();
            m_busy = sets_c;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        @(negedge clk);
        checkOutput("init_done_o", 64'(init_done_o), 64'(m_busy == 0));
        checkOutput("pf_v_o", 64'(pf_v_o), 64'(m_pf_v));
        checkOutput("pf_addr_o", 64'(pf_addr_o), 64'(m_pf_addr));
        checkOutput("pf_pc_o", 64'(pf_pc_o), 64'(m_pf_pc));
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic doLoad(input logic [va_w-1:0] pc, input logic [va_w-1:0] addr, input bit rdy);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 40) begin
            applyStimulus(1'b1, pc, addr, rdy, 1'b0, acc);
            n++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $error("[TB] FAIL load_timeout: observed no accept after %0d cycles, expected accept", n);
        end
    endtask

    task automatic waitInit(output int cnt);
        cnt = 0;
        while (init_done_o !== 1'b1 && cnt < 100) begin
            idle(1);
            cnt++;
        end
    endtask

    logic [va_w-1:0] rpc   [8];
    int              rstr  [8];
    logic [va_w-1:0] rlast [8];
    logic [va_w-1:0] addr;
    int              cnt, k;
    bit              acc;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n_i  = 1'b0;
        flush_i    = 1'b0;
        v_i        = 1'b0;
        pc_i       = '0;
        eff_addr_i = '0;
        pf_ready_i = 1'b0;
        modelClear();
        m_p_v = 1'b0; m_p_pc = '0; m_p_addr = '0;
        m_pf_v = 1'b0; m_pf_addr = '0; m_pf_pc = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_init_done", 64'(init_done_o), 64'd0);
        checkOutput("rst_ready", 64'(ready_o), 64'd0);
        checkOutput("rst_pf_v", 64'(pf_v_o), 64'd0);
        checkOutput("rst_pf_addr", 64'(pf_addr_o), 64'd0);
        checkOutput("rst_pf_pc", 64'(pf_pc_o), 64'd0);

        reset_n_i = 1'b1;
        m_busy    = sets_c + 1;
        waitInit(cnt);
        checkOutput("init_latency", 64'(cnt), 64'(sets_c + 1));

        $display("[TB] positive stride");
        doLoad(39'h100, 39'h1000, 1'b1);
        doLoad(39'h100, 39'h1040, 1'b1);
        doLoad(39'h100, 39'h1080, 1'b1);
        doLoad(39'h100, 39'h10C0, 1'b1);
        idle(1);
        checkOutput("pos_pf_v", 64'(pf_v_o), 64'd1);
        checkOutput("pos_pf_addr", 64'(pf_addr_o), 64'h1100);
        checkOutput("pos_pf_pc", 64'(pf_pc_o), 64'h100);

        $display("[TB] negative stride");
        doLoad(39'h200, 39'h2000, 1'b1);
        doLoad(39'h200, 39'h1FF8, 1'b1);
        doLoad(39'h200, 39'h1FF0, 1'b1);
        doLoad(39'h200, 39'h1FE8, 1'b1);
        idle(1);
        checkOutput("neg_pf_addr", 64'(pf_addr_o), 64'h1FE0);
        checkOutput("neg_pf_pc", 64'(pf_pc_o), 64'h200);

        $display("[TB] eviction in set 0");
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, acc);
        waitInit(cnt);
        for (int i = 0; i < 4; i++) doLoad(39'h400, 39'h4000 + 39'(8 * i), 1'b1);
        idle(1);
        for (int i = 1; i < 5; i++) doLoad(39'h400 + 39'(32 * i), 39'h9000 + 39'(i * 256), 1'b1);
        doLoad(39'h400, 39'h4020, 1'b1);
        idle(1);
        checkOutput("evict_no_pf", 64'(pf_v_o), 64'd0);

        $display("[TB] prefetch backpressure");
        addr = 39'h5000;
        repeat (10) begin
            applyStimulus(1'b1, 39'hA5, addr, 1'b0, 1'b0, acc);
            if (acc) addr += 39'h40;
        end
        checkOutput("bp_ready_low", 64'(ready_o), 64'd0);
        checkOutput("bp_pf_hold", 64'(pf_addr_o), 64'h5100);
        repeat (3) begin
            doLoad(39'hA5, addr, 1'b1);
            addr += 39'h40;
        end
        idle(1);
        checkOutput("bp_resume_addr", 64'(pf_addr_o), 64'h5200);

        $display("[TB] flush after training");
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, acc);
        waitInit(cnt);
        checkOutput("flush_clear_len", 64'(cnt), 64'(sets_c));
        doLoad(39'hA5, 39'h5200, 1'b1);
        doLoad(39'hA5, 39'h5240, 1'b1);
        doLoad(39'hA5, 39'h5280, 1'b1);
        idle(1);
        checkOutput("retrain_early", 64'(pf_v_o), 64'd0);
        doLoad(39'hA5, 39'h52C0, 1'b1);
        idle(1);
        checkOutput("retrain_pf_v", 64'(pf_v_o), 64'd1);
        checkOutput("retrain_pf_addr", 64'(pf_addr_o), 64'h5300);

        $display("[TB] address wrap");
        for (int i = 0; i < 4; i++) doLoad(39'h7, 39'h7F_FFFF_FF00 + 39'(64 * i), 1'b1);
        idle(1);
        checkOutput("wrap_pf_v", 64'(pf_v_o), 64'd1);
        checkOutput("wrap_pf_addr", 64'(pf_addr_o), 64'h0);

        $display("[TB] random traffic");
        rpc = '{39'h300, 39'h320, 39'h340, 39'h360, 39'h380, 39'h13, 39'h33, 39'h7F_0000_0007};
        rstr = '{8, -16, 64, -2048, 2047, 4, -4, 256};
        for (int i = 0; i < 8; i++) rlast[i] = 39'h10_0000 * 39'(i + 1);
        for (int c = 0; c < 800; c++) begin
            k = $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0)
                addr = {7'($urandom), $urandom};
            else
                addr = rlast[k] + 39'(rstr[k]);
            applyStimulus($urandom_range(0, 9) < 7, rpc[k], addr, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 199) == 0, acc);
            if (acc) rlast[k] = addr;
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
